// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   EX-stage execute unit. ADD/SUB/AND/OR, illegal codes and zero-amount
//   shifts finish on the accept edge. Non-zero shifts move one bit per
//   cycle. MUL is a shift-add that takes exactly WIDTH cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start_i    request; taken only while ready_o is high
//   control_i  4-bit ALU control code, sampled at accept
//   a_i, b_i   operands, sampled at accept
//   ready_o    unit is idle and can accept a request this cycle
//   done_o     one-cycle pulse; result_o/zero_o/illegal_o are new
//   result_o   result, held until the next done_o
//   zero_o     result_o == 0, held with result_o
//   illegal_o  accepted code was unsupported, held with result_o
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | ready; single-cycle ops are written on the accept edge
// S_SHIFT | one bit per cycle, r_cnt counts down the remaining bits
// S_MUL   | shift-add, one multiplier bit per cycle, WIDTH cycles

module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       control_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic [1:0]       r_state;
  logic [3:0]       r_ctrl;
  logic [WIDTH-1:0] r_val;     // shift operand, or multiplicand during MUL
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic             r_done;

  logic             w_accept;
  logic             w_is_shift;
  logic [SW-1:0]    w_amt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ill;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_acc_next;

  assign w_accept   = start_i && (r_state == S_IDLE);
  assign w_amt      = b_i[SW-1:0];
  assign w_is_shift = (control_i == OP_SLL) || (control_i == OP_SRL) ||
                      (control_i == OP_SRA);

  // Single-cycle result. For shifts this is only used when the amount is
  // zero, where the result is simply operand A.
  always_comb begin
    w_alu_res = '0;
    w_alu_ill = 1'b0;
    case (control_i)
      OP_ADD:                 w_alu_res = a_i + b_i;
      OP_SUB:                 w_alu_res = a_i - b_i;
      OP_AND:                 w_alu_res = a_i & b_i;
      OP_OR:                  w_alu_res = a_i | b_i;
      OP_SLL, OP_SRL, OP_SRA: w_alu_res = a_i;
      OP_MUL:                 w_alu_res = '0;
      default:                w_alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_shift_next = {1'b0, r_val[WIDTH-1:1]};
    case (r_ctrl)
      OP_SLL:  w_shift_next = {r_val[WIDTH-2:0], 1'b0};
      OP_SRA:  w_shift_next = {r_val[WIDTH-1], r_val[WIDTH-1:1]};
      default: w_shift_next = {1'b0, r_val[WIDTH-1:1]};
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + r_val) : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_val     <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ctrl <= control_i;
            if (control_i == OP_MUL) begin
              r_val    <= a_i;
              r_mplier <= b_i;
              r_acc    <= '0;
              r_cnt    <= CW'(WIDTH);
              r_state  <= S_MUL;
            end else if (w_is_shift && (w_amt != '0)) begin
              r_val   <= a_i;
              r_cnt   <= {1'b0, w_amt};
              r_state <= S_SHIFT;
            end else begin
              r_result  <= w_alu_res;
              r_zero    <= (w_alu_res == '0);
              r_illegal <= w_alu_ill;
              r_done    <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_val <= w_shift_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result  <= w_shift_next;
            r_zero    <= (w_shift_next == '0);
            r_illegal <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_val    <= {r_val[WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result  <= w_acc_next;
            r_zero    <= (w_acc_next == '0);
            r_illegal <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o   = (r_state == S_IDLE);
  assign done_o    = r_done;
  assign result_o  = r_result;
  assign zero_o    = r_zero;
  assign illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [3:0]   control_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         ready_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         illegal_o;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .control_i (control_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .ready_o   (ready_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .illegal_o (illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: direct operators, not the iterative datapath.
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    logic [4:0] sh;
    sh    = b[4:0];
    e.ill = 1'b0;
    e.res = '0;
    case (c)
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0011: e.res = a << sh;
      4'b0100: e.res = a >> sh;
      4'b0101: e.res = $unsigned($signed(a) >>> sh);
      4'b1000: e.res = a * b;
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Drive a request and record its expected outcome.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    control_i = c;
    a_i       = a;
    b_i       = b;
    start_i   = 1'b1;
    sb.push_back(model(c, a, b));
  endtask

  task automatic test_reset();
    exp_t e;
    int   stray;
    rst = 1'b1; start_i = 1'b0; control_i = '0; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready_o, done_o, zero_o, illegal_o, result_o} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_state: got rdy=%b done=%b zero=%b ill=%b res=%h, need 1 0 1 0 00000000",
               ready_o, done_o, zero_o, illegal_o, result_o);
    end
    rst = 1'b0;
    @(negedge clk);
    issue(4'b1000, 32'd5, 32'd7);
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_busy_before_reset: ready_o got %b need 0", ready_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    n_checks++;
    if ({ready_o, done_o, zero_o, illegal_o, result_o} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_mid_mul: got rdy=%b done=%b zero=%b ill=%b res=%h, need 1 0 1 0 00000000",
               ready_o, done_o, zero_o, illegal_o, result_o);
    end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_errors++;
      $display("FAIL aborted_mul_done: got %0d done pulses need 0", stray);
    end
    issue(4'b0010, 32'd3, 32'd4);
    @(negedge clk);
    start_i = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({done_o, result_o, zero_o, illegal_o} !== {1'b1, e.res, e.zero, e.ill}) begin
      n_errors++;
      $display("FAIL add_after_reset: got done=%b res=%h z=%b i=%b need 1 %h %b %b",
               done_o, result_o, zero_o, illegal_o, e.res, e.zero, e.ill);
    end
    @(negedge clk);
    n_checks++;
    if ({done_o, result_o} !== {1'b0, 32'd7}) begin
      n_errors++;
      $display("FAIL done_pulse_hold: got done=%b res=%h need 0 00000007", done_o, result_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   c [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
    logic [W-1:0] a [4] = '{32'hFFFFFFFF, 32'd5, 32'hF0F0F0F0, 32'h0F};
    logic [W-1:0] b [4] = '{32'h1, 32'd7, 32'hFF00FF00, 32'hF0};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(c[i], a[i], b[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({done_o, ready_o, result_o, zero_o, illegal_o} !== {1'b1, 1'b1, e.res, e.zero, e.ill}) begin
        n_errors++;
        $display("FAIL b2b_op%0d: got done=%b rdy=%b res=%h z=%b i=%b need 1 1 %h %b %b",
                 i, done_o, ready_o, result_o, zero_o, illegal_o, e.res, e.zero, e.ill);
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done_o !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_end_done: got %b need 0", done_o);
    end
  endtask

  task automatic test_shift();
    logic [3:0]   c [4] = '{4'b0101, 4'b0100, 4'b0011, 4'b0011};
    logic [W-1:0] a [4] = '{32'h80000000, 32'h80000000, 32'h1, 32'h1};
    logic [W-1:0] b [4] = '{32'h23, 32'h23, 32'h0, 32'h1F};
    int           k [4] = '{3, 3, 0, 31};
    exp_t e;
    int   n, low;
    for (int i = 0; i < 4; i++) begin
      issue(c[i], a[i], b[i]);
      @(negedge clk);
      start_i = 1'b0;
      n = 1; low = 0;
      while (!done_o && n < 200) begin
        if (!ready_o) low++;
        @(negedge clk);
        n++;
      end
      e = sb.pop_front();
      n_checks++;
      if (done_o !== 1'b1) begin
        n_errors++;
        $display("FAIL shift%0d_timeout: no done_o after %0d cycles", i, n);
      end
      n_checks++;
      if ((n - 1) != k[i] || low != k[i] || ready_o !== 1'b1) begin
        n_errors++;
        $display("FAIL shift%0d_timing: got latency=%0d busy=%0d rdy=%b need %0d %0d 1",
                 i, n - 1, low, ready_o, k[i], k[i]);
      end
      n_checks++;
      if ({result_o, zero_o, illegal_o} !== {e.res, e.zero, e.ill}) begin
        n_errors++;
        $display("FAIL shift%0d_result: got %h z=%b i=%b need %h %b %b",
                 i, result_o, zero_o, illegal_o, e.res, e.zero, e.ill);
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] a [3] = '{32'h00010001, 32'hFFFFFFFF, 32'h00000000};
    logic [W-1:0] b [3] = '{32'h00010001, 32'hFFFFFFFF, 32'h12345678};
    exp_t e;
    int   n, extra;
    for (int i = 0; i < 3; i++) begin
      issue(4'b1000, a[i], b[i]);
      @(negedge clk);
      start_i = 1'b0;
      n = 1;
      while (!done_o && n < 200) begin
        // Poke the unit with other requests while it is busy.
        if (i == 1 && (n % 5) == 0) begin
          start_i = 1'b1; control_i = 4'b0010; a_i = 32'd1; b_i = 32'd1;
        end else begin
          start_i = 1'b0;
        end
        @(negedge clk);
        n++;
      end
      start_i = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (done_o !== 1'b1 || (n - 1) != W) begin
        n_errors++;
        $display("FAIL mul%0d_latency: got done=%b latency=%0d need 1 %0d", i, done_o, n - 1, W);
      end
      n_checks++;
      if ({result_o, zero_o, illegal_o} !== {e.res, e.zero, e.ill}) begin
        n_errors++;
        $display("FAIL mul%0d_result: got %h z=%b i=%b need %h %b %b",
                 i, result_o, zero_o, illegal_o, e.res, e.zero, e.ill);
      end
      extra = 0;
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        if (done_o) extra++;
      end
      n_checks++;
      if (extra != 0 || result_o !== e.res) begin
        n_errors++;
        $display("FAIL mul%0d_single_done: got extra=%0d res=%h need 0 %h", i, extra, result_o, e.res);
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    issue(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({done_o, ready_o, result_o, zero_o, illegal_o} !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b1} ||
        e.ill !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_op: got done=%b rdy=%b res=%h z=%b i=%b need 1 1 00000000 1 1",
               done_o, ready_o, result_o, zero_o, illegal_o);
    end
    issue(4'b0010, 32'd1, 32'd1);
    @(negedge clk);
    start_i = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({done_o, result_o, zero_o, illegal_o} !== {1'b1, e.res, e.zero, e.ill}) begin
      n_errors++;
      $display("FAIL illegal_clear: got done=%b res=%h z=%b i=%b need 1 %h %b %b",
               done_o, result_o, zero_o, illegal_o, e.res, e.zero, e.ill);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_shift();
    test_mul();
    test_illegal();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries need 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation on two WIDTH-bit operands. Single-cycle logic/arithmetic ops complete in one cycle. Shifts and multiply run iteratively. The unit sits in the EX stage behind a start/ready/done handshake so the pipeline controller can stall on long operations.

## Interface
- WIDTH, 32, operand/result width; power of two, >= 8
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  request; accepted only when ready_o is high
- control_i  in  4  operation code, sampled at accept
- a_i  in  WIDTH  operand A, sampled at accept
- b_i  in  WIDTH  operand B, sampled at accept
- ready_o  out  1  unit can accept a request this cycle
- done_o  out  1  one-cycle pulse: result_o/zero_o/illegal_o valid
- result_o  out  WIDTH  result; held until the next done_o
- zero_o  out  1  result_o == 0; held with result_o
- illegal_o  out  1  the accepted control code was unsupported; held with result_o

## Operation
- Codes:
  - 0010 ADD: a+b, wrap mod 2^WIDTH.
  - 0110 SUB: a-b, wrap mod 2^WIDTH.
  - 0000 AND.
  - 0001 OR.
  - 0011 SLL.
  - 0100 SRL.
  - 0101 SRA.
  - 1000 MUL: low WIDTH bits of unsigned a*b.
- Other codes are illegal. They complete as a 1-cycle op with result_o=0, zero_o=1 and illegal_o=1. illegal_o=0 for all legal codes.
- Shift amount is b_i[log2(WIDTH)-1:0]. Upper bits are ignored.
- States:
  - IDLE: ready_o=1.
  - SHIFT: shifts 1 bit per cycle, decrementing a counter loaded with the shift amount.
  - MUL: shift-add, 1 multiplier bit per cycle, WIDTH iterations.
  - There is no separate DONE state; done_o is registered alongside the final result.
- Transitions:
  - IDLE -> SHIFT on accept of a shift code with nonzero amount.
  - IDLE -> MUL on accept of MUL.
  - SHIFT/MUL -> IDLE on the edge that writes the final result.
  - ADD/SUB/AND/OR/illegal codes and zero-amount shifts stay in IDLE. Their result is written on the accept edge.
- start_i while ready_o=0 is ignored. No queuing; control_i/a_i/b_i changes while busy have no effect.
- SRA fills with the sign bit of the latched a. SLL/SRL fill with 0.
- MUL uses internal registers: WIDTH-bit accumulator, shifted multiplicand, multiplier, log2(WIDTH)+1-bit counter.
- rst at any time, including mid-operation:
  - state -> IDLE and the operation is aborted.
  - ready_o=1, done_o=0, result_o=0, zero_o=1, illegal_o=0.
  - Internal counters and accumulators are cleared.
- zero_o is registered from the final result, never computed combinationally from partial results.

## Timing
- Accept at rising edge N: start_i=1 and ready_o=1 sampled at edge N.
- 1-cycle ops (ADD, SUB, AND, OR, illegal, shift with amount 0):
  - result written at edge N; done_o high in cycle N..N+1.
  - ready_o stays 1.
- Shift with amount k (1..WIDTH-1):
  - ready_o=0 from edge N.
  - result written at edge N+k; done_o high for the following cycle.
  - ready_o=1 in that same cycle.
- MUL:
  - ready_o=0 from edge N.
  - done_o follows edge N+WIDTH; latency is WIDTH cycles regardless of operand values.
- Back-to-back: a request presented while done_o=1 (ready_o=1) is accepted. Zero bubbles for 1-cycle ops, so done_o can stay high on consecutive cycles.
- done_o never asserts without a preceding accept. result_o/zero_o/illegal_o change only on edges where done_o is set, or on reset.

## Test plan
- Reset: assert rst mid-MUL, release -> ready_o=1, done_o=0, result_o=0, zero_o=1. The next ADD 3+4 gives 7 one cycle after accept.
- 1-cycle ops, WIDTH=32, back-to-back on consecutive cycles:
  - ADD 0xFFFFFFFF+1 -> 0, zero_o=1.
  - SUB 5-7 -> 0xFFFFFFFE.
  - AND 0xF0F0F0F0&0xFF00FF00 -> 0xF000F000.
  - OR 0x0F&0xF0 operands -> 0xFF.
  - Expected: done_o high 4 consecutive cycles, ready_o never low.
- Shifts:
  - SRA 0x80000000 by b=0x23 (amount 3) -> 0xF0000000; done_o 3 cycles after accept; ready_o low for exactly 3 cycles.
  - SRL same operands -> 0x10000000.
  - SLL 1 by 0 -> 1, 1-cycle latency.
- MUL:
  - 0x00010001*0x00010001 -> 0x00020001 after exactly 32 cycles.
  - 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
  - start_i pulses with other codes while busy are ignored (single done_o).
- Illegal: control_i=1111 with a=b=0xFFFFFFFF -> result_o=0, zero_o=1, illegal_o=1, 1-cycle latency. The next legal op clears illegal_o.
